// File: rtl/mips_pkg.sv
// Shared pipeline encodings for the MIPS-R2000 core: control-bit positions
// inside the EX/MEM and MEM/WB control fields, and the MEM-stage FSM states.
package mips_pkg;

  localparam int M_BRANCH    = 2;
  localparam int M_READ      = 1;
  localparam int M_WRITE     = 0;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with bubble insertion and the write-back data mux
// (load data versus ALU result, selected by the registered mem_to_reg bit).
import mips_pkg::*;

module mem_wb_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bubble,
  input  logic [1:0]  wb_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] mem_in,
  output logic [1:0]  wb_WB,
  output logic [4:0]  rd_WB,
  output logic [31:0] write_data_reg
);

  logic [31:0] alu_res_q;
  logic [31:0] mem_data_q;

  // A bubble clears the whole entry so forwarding never sees a stale rd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_WB      <= 2'b00;
      rd_WB      <= 5'd0;
      alu_res_q  <= 32'd0;
      mem_data_q <= 32'd0;
    end else if (bubble) begin
      wb_WB      <= 2'b00;
      rd_WB      <= 5'd0;
      alu_res_q  <= 32'd0;
      mem_data_q <= 32'd0;
    end else begin
      wb_WB      <= wb_in;
      rd_WB      <= rd_in;
      alu_res_q  <= alu_in;
      mem_data_q <= mem_in;
    end
  end

  assign write_data_reg = wb_WB[WB_MEMTOREG] ? mem_data_q : alu_res_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives the data-memory req/gnt/rvalid bus, stalls upstream while
// an access is outstanding, aborts on timeout, resolves branches, feeds MEM/WB.
import mips_pkg::*;

module mem_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   res,
  input  logic [31:0]   write_data_ex,
  input  logic [4:0]    write_register_ex,
  input  logic [2:0]    m_MEM,
  input  logic [1:0]    wb_MEM,
  input  logic          zero,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [31:0]   dmem_wdata,
  input  logic          dmem_gnt,
  input  logic          dmem_rvalid,
  input  logic [31:0]   dmem_rdata,
  output logic          mem_stall,
  output logic          pc_src,
  output logic [1:0]    wb_WB,
  output logic [4:0]    rd_WB,
  output logic [31:0]   write_data_reg,
  output logic          misalign_err,
  output logic          bus_err
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  mem_state_t state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  logic access, is_write, misaligned, mem_go;
  logic at_limit, done, timeout;

  // When both read and write are set the write wins.
  assign access     = m_MEM[M_READ] | m_MEM[M_WRITE];
  assign is_write   = m_MEM[M_WRITE];
  assign misaligned = access & (res[1:0] != 2'b00);
  assign mem_go     = access & ~misaligned;
  assign at_limit   = (wait_cnt_q == WAIT_LAST);

  assign dmem_we    = is_write;
  assign dmem_addr  = res[AW-1:0];
  assign dmem_wdata = write_data_ex;

  always_comb begin
    state_d  = state_q;
    dmem_req = 1'b0;
    done     = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_go) begin
          dmem_req = 1'b1;
          if (dmem_gnt) begin
            if (is_write) done = 1'b1;
            else          state_d = RESP;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (at_limit) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          dmem_req = 1'b1;
          if (dmem_gnt) begin
            if (is_write) begin
              done    = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = RESP;
            end
          end
        end
      end
      RESP: begin
        // rvalid is only meaningful here; a response seen elsewhere is stale.
        if (dmem_rvalid) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (at_limit) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wait_cnt_d = 8'd0;
    if (state_d == state_q && state_q != IDLE) wait_cnt_d = wait_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign mem_stall    = mem_go & ~done & ~timeout;
  assign pc_src       = m_MEM[M_BRANCH] & zero & ~mem_stall;
  assign misalign_err = misaligned;
  assign bus_err      = timeout;

  mem_wb_reg u_mem_wb (
    .clk            (clk),
    .rst_n          (rst_n),
    .bubble         (mem_stall | misaligned | timeout),
    .wb_in          (wb_MEM),
    .rd_in          (write_register_ex),
    .alu_in         (res),
    .mem_in         (dmem_rdata),
    .wb_WB          (wb_WB),
    .rd_WB          (rd_WB),
    .write_data_reg (write_data_reg)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with TIMEOUT=4: pass-through, stores,
// loads with waits, misalignment, timeout, reset mid-access and branches.
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] res;
  logic [31:0] write_data_ex;
  logic [4:0]  write_register_ex;
  logic [2:0]  m_MEM;
  logic [1:0]  wb_MEM;
  logic        zero;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic        pc_src;
  logic [1:0]  wb_WB;
  logic [4:0]  rd_WB;
  logic [31:0] write_data_reg;
  logic        misalign_err;
  logic        bus_err;

  int checks = 0;
  int errors = 0;
  int stall_cnt;

  mem_access_stage #(.TIMEOUT(4), .AW(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .res               (res),
    .write_data_ex     (write_data_ex),
    .write_register_ex (write_register_ex),
    .m_MEM             (m_MEM),
    .wb_MEM            (wb_MEM),
    .zero              (zero),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_gnt          (dmem_gnt),
    .dmem_rvalid       (dmem_rvalid),
    .dmem_rdata        (dmem_rdata),
    .mem_stall         (mem_stall),
    .pc_src            (pc_src),
    .wb_WB             (wb_WB),
    .rd_WB             (rd_WB),
    .write_data_reg    (write_data_reg),
    .misalign_err      (misalign_err),
    .bus_err           (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and registers are read here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    res = 32'd0; write_data_ex = 32'd0; write_register_ex = 5'd0;
    m_MEM = 3'b000; wb_MEM = 2'b00; zero = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #12;
    check("rst_wb",     {30'd0, wb_WB},  32'd0);
    check("rst_rd",     {27'd0, rd_WB},  32'd0);
    check("rst_wdata",  write_data_reg,  32'd0);
    check("rst_stall",  {31'd0, mem_stall}, 32'd0);
    check("rst_req",    {31'd0, dmem_req},  32'd0);
    check("rst_errs",   {30'd0, misalign_err, bus_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ALU pass-through
    m_MEM = 3'b000; wb_MEM = 2'b10; res = 32'h1234; write_register_ex = 5'd5;
    @(negedge clk);
    check("alu_req",   {31'd0, dmem_req},  32'd0);
    check("alu_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    check("alu_wb",    {30'd0, wb_WB}, 32'd2);
    check("alu_rd",    {27'd0, rd_WB}, 32'd5);
    check("alu_data",  write_data_reg, 32'h1234);

    // Zero-wait store
    idle_inputs();
    m_MEM = 3'b001; res = 32'h100; write_data_ex = 32'hDEADBEEF; dmem_gnt = 1'b1;
    @(negedge clk);
    check("st_req",   {31'd0, dmem_req},  32'd1);
    check("st_we",    {31'd0, dmem_we},   32'd1);
    check("st_addr",  dmem_addr,          32'h100);
    check("st_wdata", dmem_wdata,         32'hDEADBEEF);
    check("st_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    check("st_wb",    {30'd0, wb_WB}, 32'd0);
    idle_inputs();
    @(negedge clk);
    check("st_req_off", {31'd0, dmem_req}, 32'd0);
    tick();

    // Store with one wait state
    m_MEM = 3'b001; res = 32'h104; write_data_ex = 32'h11112222;
    @(negedge clk);
    check("stw_stall0", {31'd0, mem_stall}, 32'd1);
    tick();
    dmem_gnt = 1'b1;
    @(negedge clk);
    check("stw_req1",   {31'd0, dmem_req},  32'd1);
    check("stw_stall1", {31'd0, mem_stall}, 32'd0);
    tick();
    idle_inputs();

    // Load: gnt after 2 cycles, rvalid 3 cycles after gnt
    m_MEM = 3'b010; wb_MEM = 2'b11; res = 32'h200; write_register_ex = 5'd8;
    stall_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      dmem_gnt    = (c == 2);
      dmem_rvalid = (c == 5);
      dmem_rdata  = (c == 5) ? 32'hCAFEF00D : 32'h0BAD0BAD;
      @(negedge clk);
      if (mem_stall) stall_cnt++;
      if (c == 1) check("ld_req_wait", {31'd0, dmem_req}, 32'd1);
      if (c == 2) check("ld_wb_bubble", {30'd0, wb_WB}, 32'd0);
      if (c == 3) check("ld_req_resp", {31'd0, dmem_req}, 32'd0);
      if (c == 5) check("ld_stall_done", {31'd0, mem_stall}, 32'd0);
      tick();
    end
    check("ld_stall_cnt", stall_cnt, 32'd5);
    check("ld_wb",   {30'd0, wb_WB}, 32'd3);
    check("ld_rd",   {27'd0, rd_WB}, 32'd8);
    check("ld_data", write_data_reg, 32'hCAFEF00D);
    idle_inputs();

    // Misaligned load
    m_MEM = 3'b010; wb_MEM = 2'b11; res = 32'h202; write_register_ex = 5'd3;
    @(negedge clk);
    check("mis_req",   {31'd0, dmem_req},     32'd0);
    check("mis_err",   {31'd0, misalign_err}, 32'd1);
    check("mis_stall", {31'd0, mem_stall},    32'd0);
    tick();
    check("mis_wb",    {30'd0, wb_WB}, 32'd0);
    idle_inputs();
    @(negedge clk);
    check("mis_err_off", {31'd0, misalign_err}, 32'd0);
    tick();

    // Timeout: gnt never arrives; abort in the fifth cycle
    m_MEM = 3'b010; wb_MEM = 2'b11; res = 32'h300; write_register_ex = 5'd9;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c < 4) begin
        check("to_stall", {31'd0, mem_stall}, 32'd1);
        check("to_noerr", {31'd0, bus_err},   32'd0);
      end else begin
        check("to_err",      {31'd0, bus_err},   32'd1);
        check("to_release",  {31'd0, mem_stall}, 32'd0);
        check("to_req_drop", {31'd0, dmem_req},  32'd0);
      end
      tick();
    end
    check("to_wb", {30'd0, wb_WB}, 32'd0);
    idle_inputs();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h55;
    @(negedge clk);
    check("to_err_off",    {31'd0, bus_err},   32'd0);
    check("to_late_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    check("to_late_data", write_data_reg, 32'd0);
    idle_inputs();

    // Reset during RESP, then a stale rvalid
    m_MEM = 3'b010; wb_MEM = 2'b11; res = 32'h400; write_register_ex = 5'd10; dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    @(negedge clk);
    check("rr_stall", {31'd0, mem_stall}, 32'd1);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("rr_stall0", {31'd0, mem_stall}, 32'd0);
    check("rr_wb0",    {30'd0, wb_WB},     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h77;
    @(negedge clk);
    check("rr_stale_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    idle_inputs();
    check("rr_stale_wb",   {30'd0, wb_WB},  32'd0);
    check("rr_stale_rd",   {27'd0, rd_WB},  32'd0);
    check("rr_stale_data", write_data_reg,  32'd0);

    // Branch resolution
    m_MEM = 3'b100; zero = 1'b1;
    @(negedge clk);
    check("br_taken", {31'd0, pc_src}, 32'd1);
    zero = 1'b0;
    #1;
    check("br_not", {31'd0, pc_src}, 32'd0);
    tick();
    // Branch held off by an outstanding load, then taken when it completes
    m_MEM = 3'b110; zero = 1'b1; res = 32'h500; dmem_gnt = 1'b1;
    @(negedge clk);
    check("br_stalled", {31'd0, pc_src}, 32'd0);
    tick();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h99;
    @(negedge clk);
    check("br_after", {31'd0, pc_src}, 32'd1);
    tick();
    idle_inputs();

    // Read and write both set: write wins, completes with no stall
    m_MEM = 3'b011; res = 32'h600; dmem_gnt = 1'b1;
    @(negedge clk);
    check("rw_we",    {31'd0, dmem_we},   32'd1);
    check("rw_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
